// File: rtl/icache_scoreboard.sv
// -----------------------------------------------------------------------------
// icache_scoreboard
// In-order response checker for the instruction-cache fetch path. It watches
// the request (addr) and response (data) handshakes without driving them.
// Each accepted address is queued, and the next accepted response is compared
// against the golden word (addr XOR SEED). Errors are reported as a sticky
// flag, and the details of the first error are captured.
//
// Optional feature: define ICACHE_SB_TIMEOUT_EN to add a response watchdog
// that raises error code 6 after TIMEOUT cycles without a response while
// requests are outstanding. Without the macro no watchdog logic is built.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   addr_valid/ready/bits        monitored request channel
//   data_valid/ready/bits        monitored response channel
//   outstanding                  queued requests not yet answered (0..DEPTH)
//   mismatch_pulse               one-cycle pulse, cycle after a bad response
//   err_sticky                   OR of every error seen since reset
//   err_code                     first error: 1 mismatch, 2 overflow,
//                                3 underflow, 4 illegal addr, 5 protocol,
//                                6 timeout
//   err_addr/expected/actual     details captured with the first error
//   checked_count                responses compared, saturating
// -----------------------------------------------------------------------------
module icache_scoreboard #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_LIMIT = 256,
    parameter logic [31:0] SEED       = 32'h5A5A_0000,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       addr_valid,
    input  logic                       addr_ready,
    input  logic [ADDR_W-1:0]          addr_bits,
    input  logic                       data_valid,
    input  logic                       data_ready,
    input  logic [DATA_W-1:0]          data_bits,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       mismatch_pulse,
    output logic                       err_sticky,
    output logic [2:0]                 err_code,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [DATA_W-1:0]          err_expected,
    output logic [DATA_W-1:0]          err_actual,
    output logic [15:0]                checked_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GW0   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned GW    = (GW0 > 32) ? GW0 : 32;
    localparam logic [ADDR_W:0] LIMIT_X = (ADDR_W+1)'(ADDR_LIMIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_MISMATCH = 3'd1;
    localparam logic [2:0] E_OVERFLOW = 3'd2;
    localparam logic [2:0] E_UNDERFL  = 3'd3;
    localparam logic [2:0] E_ILLEGAL  = 3'd4;
    localparam logic [2:0] E_PROTO    = 3'd5;
    localparam logic [2:0] E_TIMEOUT  = 3'd6;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mismatch_pulse_q, mismatch_pulse_d;
    logic [15:0]       checked_q, checked_d;
    logic              err_sticky_q, err_sticky_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_act_q, err_act_d;
    logic              data_stall_q, data_stall_d;
    logic [DATA_W-1:0] data_prev_q, data_prev_d;
    logic              addr_stall_q, addr_stall_d;
    logic [ADDR_W-1:0] addr_prev_q, addr_prev_d;

    logic              push_fire, pop_fire;
    logic              empty, full;
    logic              do_push, do_pop;
    logic              overflow, underflow, illegal, mismatch, proto_err;
    logic              timeout_err;
    logic [ADDR_W-1:0] head;
    logic [DATA_W-1:0] golden;
    logic [GW-1:0]     golden_wide;
    logic [2:0]        new_code;
    logic [ADDR_W-1:0] new_addr;

    assign push_fire = addr_valid & addr_ready;
    assign pop_fire  = data_valid & data_ready;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head      = mem_q[rd_ptr_q];

    // Golden word: address XOR seed, zero-extended or truncated to DATA_W.
    assign golden_wide = GW'(head) ^ GW'(SEED);
    assign golden      = golden_wide[DATA_W-1:0];

    // Queue is judged on its state before this cycle's push, so a push into an
    // empty queue cannot answer a same-cycle response.
    assign underflow = pop_fire & empty;
    assign do_pop    = pop_fire & ~empty;
    // When full, a simultaneous pop makes room, so only push-without-pop overflows.
    assign overflow  = push_fire & full & ~pop_fire;
    assign do_push   = push_fire & ~overflow;
    assign illegal   = push_fire & ((addr_bits[1:0] != 2'b00) |
                                    ({1'b0, addr_bits} >= LIMIT_X));
    assign mismatch  = do_pop & (data_bits != golden);
    assign proto_err = (data_stall_q & (~data_valid | (data_bits != data_prev_q))) |
                       (addr_stall_q & (~addr_valid | (addr_bits != addr_prev_q)));

`ifdef ICACHE_SB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    logic [TW-1:0] wd_q, wd_d;

    // Saturates at T_MAX so the timeout is flagged only once per stall.
    always_comb begin
        wd_d        = wd_q;
        timeout_err = 1'b0;
        if (empty || pop_fire) begin
            wd_d = '0;
        end else if (wd_q != T_MAX) begin
            wd_d        = wd_q + 1'b1;
            timeout_err = (wd_d == T_MAX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Highest-priority error this cycle.
    always_comb begin
        new_code = E_NONE;
        new_addr = '0;
        if (mismatch) begin
            new_code = E_MISMATCH;
            new_addr = head;
        end else if (overflow) begin
            new_code = E_OVERFLOW;
            new_addr = addr_bits;
        end else if (underflow) begin
            new_code = E_UNDERFL;
        end else if (illegal) begin
            new_code = E_ILLEGAL;
            new_addr = addr_bits;
        end else if (proto_err) begin
            new_code = E_PROTO;
        end else if (timeout_err) begin
            new_code = E_TIMEOUT;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = addr_bits;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

        mismatch_pulse_d = mismatch;
        checked_d        = checked_q;
        if (do_pop && checked_q != 16'hFFFF) begin
            checked_d = checked_q + 16'd1;
        end

        err_sticky_d = err_sticky_q | (new_code != E_NONE);
        err_code_d   = err_code_q;
        err_addr_d   = err_addr_q;
        err_exp_d    = err_exp_q;
        err_act_d    = err_act_q;
        if (err_code_q == E_NONE && new_code != E_NONE) begin
            err_code_d = new_code;
            err_addr_d = new_addr;
            err_exp_d  = mismatch ? golden    : '0;
            err_act_d  = mismatch ? data_bits : '0;
        end

        data_stall_d = data_valid & ~data_ready;
        data_prev_d  = data_bits;
        addr_stall_d = addr_valid & ~addr_ready;
        addr_prev_d  = addr_bits;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            mismatch_pulse_q <= 1'b0;
            checked_q        <= '0;
            err_sticky_q     <= 1'b0;
            err_code_q       <= E_NONE;
            err_addr_q       <= '0;
            err_exp_q        <= '0;
            err_act_q        <= '0;
            data_stall_q     <= 1'b0;
            data_prev_q      <= '0;
            addr_stall_q     <= 1'b0;
            addr_prev_q      <= '0;
        end else begin
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            mismatch_pulse_q <= mismatch_pulse_d;
            checked_q        <= checked_d;
            err_sticky_q     <= err_sticky_d;
            err_code_q       <= err_code_d;
            err_addr_q       <= err_addr_d;
            err_exp_q        <= err_exp_d;
            err_act_q        <= err_act_d;
            data_stall_q     <= data_stall_d;
            data_prev_q      <= data_prev_d;
            addr_stall_q     <= addr_stall_d;
            addr_prev_q      <= addr_prev_d;
        end
    end

    assign outstanding    = count_q;
    assign mismatch_pulse = mismatch_pulse_q;
    assign err_sticky     = err_sticky_q;
    assign err_code       = err_code_q;
    assign err_addr       = err_addr_q;
    assign err_expected   = err_exp_q;
    assign err_actual     = err_act_q;
    assign checked_count  = checked_q;

endmodule

// File: tb/tb_icache_scoreboard.sv
module tb_icache_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        addr_valid, addr_ready;
    logic [31:0] addr_bits;
    logic        data_valid, data_ready;
    logic [31:0] data_bits;
    logic [2:0]  outstanding;
    logic        mismatch_pulse;
    logic        err_sticky;
    logic [2:0]  err_code;
    logic [31:0] err_addr, err_expected, err_actual;
    logic [15:0] checked_count;

    int n_cmp = 0;
    int n_err = 0;

    icache_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .addr_valid     (addr_valid),
        .addr_ready     (addr_ready),
        .addr_bits      (addr_bits),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data_bits      (data_bits),
        .outstanding    (outstanding),
        .mismatch_pulse (mismatch_pulse),
        .err_sticky     (err_sticky),
        .err_code       (err_code),
        .err_addr       (err_addr),
        .err_expected   (err_expected),
        .err_actual     (err_actual),
        .checked_count  (checked_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        addr_valid = 1'b0; addr_ready = 1'b0; addr_bits = '0;
        data_valid = 1'b0; data_ready = 1'b0; data_bits = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        idle();
        addr_valid = 1'b1; addr_ready = 1'b1; addr_bits = a;
        tick();
        idle();
    endtask

    task automatic resp(input logic [31:0] d);
        idle();
        data_valid = 1'b1; data_ready = 1'b1; data_bits = d;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        chk("rst_outstanding", 64'(outstanding), 0);
        chk("rst_sticky", 64'(err_sticky), 0);
        chk("rst_code", 64'(err_code), 0);
        chk("rst_checked", 64'(checked_count), 0);
        chk("rst_pulse", 64'(mismatch_pulse), 0);

        // Single request, response three cycles later.
        push(32'h10);
        chk("t1_out1", 64'(outstanding), 1);
        tick(); tick();
        resp(32'h5A5A_0010);
        chk("t1_pulse", 64'(mismatch_pulse), 0);
        chk("t1_checked", 64'(checked_count), 1);
        chk("t1_out0", 64'(outstanding), 0);
        chk("t1_code", 64'(err_code), 0);

        // Four outstanding, last response wrong.
        push(32'h00); push(32'h04); push(32'h08); push(32'h0C);
        chk("t2_out4", 64'(outstanding), 4);
        resp(32'h5A5A_0000);
        chk("t2_p0", 64'(mismatch_pulse), 0);
        resp(32'h5A5A_0004);
        chk("t2_p1", 64'(mismatch_pulse), 0);
        resp(32'h5A5A_0008);
        chk("t2_p2", 64'(mismatch_pulse), 0);
        resp(32'hDEAD_BEEF);
        chk("t2_pulse", 64'(mismatch_pulse), 1);
        chk("t2_code", 64'(err_code), 1);
        chk("t2_addr", 64'(err_addr), 64'h0C);
        chk("t2_exp", 64'(err_expected), 64'h5A5A_000C);
        chk("t2_act", 64'(err_actual), 64'hDEAD_BEEF);
        chk("t2_sticky", 64'(err_sticky), 1);
        chk("t2_checked", 64'(checked_count), 5);
        tick();
        chk("t2_pulse_off", 64'(mismatch_pulse), 0);

        // Full queue: simultaneous push/pop is legal, push alone overflows.
        do_reset();
        push(32'h00); push(32'h04); push(32'h08); push(32'h0C);
        addr_valid = 1'b1; addr_ready = 1'b1; addr_bits = 32'h10;
        data_valid = 1'b1; data_ready = 1'b1; data_bits = 32'h5A5A_0000;
        tick();
        idle();
        chk("t3_simul_out", 64'(outstanding), 4);
        chk("t3_simul_code", 64'(err_code), 0);
        chk("t3_simul_chk", 64'(checked_count), 1);
        push(32'h20);
        chk("t3_ovf_code", 64'(err_code), 2);
        chk("t3_ovf_addr", 64'(err_addr), 64'h20);
        chk("t3_ovf_out", 64'(outstanding), 4);
        resp(32'h5A5A_0004);
        chk("t3_d0", 64'(mismatch_pulse), 0);
        resp(32'h5A5A_0008);
        chk("t3_d1", 64'(mismatch_pulse), 0);
        resp(32'h5A5A_000C);
        chk("t3_d2", 64'(mismatch_pulse), 0);
        resp(32'h5A5A_0010);
        chk("t3_d3", 64'(mismatch_pulse), 0);
        chk("t3_drain_out", 64'(outstanding), 0);
        chk("t3_drain_chk", 64'(checked_count), 5);
        chk("t3_code_kept", 64'(err_code), 2);

        // Reset mid-stream clears everything.
        push(32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_out", 64'(outstanding), 0);
        chk("rst2_sticky", 64'(err_sticky), 0);
        chk("rst2_code", 64'(err_code), 0);
        chk("rst2_addr", 64'(err_addr), 0);
        chk("rst2_chk", 64'(checked_count), 0);

        // Underflow, then illegal address only keeps sticky.
        resp(32'h1234_5678);
        chk("t4_uf_code", 64'(err_code), 3);
        chk("t4_uf_chk", 64'(checked_count), 0);
        chk("t4_uf_addr", 64'(err_addr), 0);
        push(32'h102);
        chk("t4_code_kept", 64'(err_code), 3);
        chk("t4_ill_out", 64'(outstanding), 1);

        // Illegal address as first error; still queued and checked in order.
        do_reset();
        push(32'h102);
        chk("t4_ill_code", 64'(err_code), 4);
        chk("t4_ill_addr", 64'(err_addr), 64'h102);
        chk("t4_ill_out1", 64'(outstanding), 1);
        resp(32'h5A5A_0102);
        chk("t4_ill_pulse", 64'(mismatch_pulse), 0);
        chk("t4_ill_chk", 64'(checked_count), 1);

        // Out-of-range but aligned address.
        do_reset();
        push(32'h100);
        chk("t4_lim_code", 64'(err_code), 4);

        // Push into empty with same-cycle response is underflow.
        do_reset();
        addr_valid = 1'b1; addr_ready = 1'b1; addr_bits = 32'h08;
        data_valid = 1'b1; data_ready = 1'b1; data_bits = 32'h5A5A_0008;
        tick();
        idle();
        chk("t4_pe_code", 64'(err_code), 3);
        chk("t4_pe_out", 64'(outstanding), 1);
        chk("t4_pe_chk", 64'(checked_count), 0);

        // Response data changed while stalled.
        do_reset();
        data_valid = 1'b1; data_ready = 1'b0; data_bits = 32'h1;
        tick();
        chk("t5_stall_ok", 64'(err_code), 0);
        data_bits = 32'h2;
        tick();
        idle();
        chk("t5_data_code", 64'(err_code), 5);
        chk("t5_data_addr", 64'(err_addr), 0);

        // Request valid dropped while stalled.
        do_reset();
        addr_valid = 1'b1; addr_ready = 1'b0; addr_bits = 32'h10;
        tick();
        idle();
        tick();
        chk("t5_addr_code", 64'(err_code), 5);
        chk("t5_addr_out", 64'(outstanding), 0);

        // Watchdog.
        do_reset();
        push(32'h10);
`ifdef ICACHE_SB_TIMEOUT_EN
        for (int i = 0; i < 63; i++) tick();
        chk("t6_pre", 64'(err_code), 0);
        tick();
        chk("t6_code", 64'(err_code), 6);
        chk("t6_addr", 64'(err_addr), 0);
`else
        for (int i = 0; i < 200; i++) tick();
        chk("t6_none", 64'(err_code), 0);
        chk("t6_sticky", 64'(err_sticky), 0);
`endif
        chk("t6_out", 64'(outstanding), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
